// File: rtl/pmod_da2_driver_pkg.sv
// Shared constants, FSM state type and the word-to-frame packing helper for the PMOD DA2 driver.
package pmod_da2_driver_pkg;

  localparam int DA2_FRAME_BITS = 16;
  localparam int DA2_DATA_BITS = 12;
  localparam logic [1:0] DA2_PD_NORMAL = 2'b00;
  localparam logic [DA2_DATA_BITS-1:0] DAC_FULL_SCALE = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_QUIET
  } da2_state_e;

  // Clamp anything above 12 bits to full scale and prepend the 4 control bits.
  function automatic logic [DA2_FRAME_BITS-1:0] da2_frame(input logic [15:0] word);
    logic [DA2_DATA_BITS-1:0] code;
    code = (|word[15:DA2_DATA_BITS]) ? DAC_FULL_SCALE : word[DA2_DATA_BITS-1:0];
    return {2'b00, DA2_PD_NORMAL, code};
  endfunction

endpackage

// File: rtl/pmod_da2_driver_if.sv
// Upstream update strobe/data plus the DAC pin bundle of the PMOD DA2 driver.
interface pmod_da2_driver_if;
  logic        load;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic        sync_n;
  logic        sclk;
  logic        dina;
  logic        dinb;
  logic        busy;
  logic        done;

  modport master (
    output load, data_a, data_b,
    input  sync_n, sclk, dina, dinb, busy, done
  );

  modport slave (
    input  load, data_a, data_b,
    output sync_n, sclk, dina, dinb, busy, done
  );
endinterface

// File: rtl/pmod_da2_driver_sclk_tick_gen.sv
// Half-period tick for SCLK: one-cycle pulse every CLK_DIV enabled cycles, count parked at 0 when disabled.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_b,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_b || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pmod_da2_driver.sv
// Serialises two clipped 12-bit words onto the PMOD DA2 shared SYNC/SCLK bus, with a one-deep pending buffer.
//   state    | meaning
//   ST_IDLE  | sync_n high, waiting for load or pending word
//   ST_FRAME | sync_n low, 16 SCLK periods shifting both channels
//   ST_QUIET | sync_n high for QUIET cycles before done
module pmod_da2_driver
  import pmod_da2_driver_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int QUIET   = 2
) (
  input logic               clk,
  input logic               reset_b,
  pmod_da2_driver_if.slave  bus
);

  localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;

  da2_state_e state;
  da2_state_e state_nxt;

  logic                      tick;
  logic                      fall_tick;
  logic                      rise_tick;
  logic                      last_rise;
  logic                      start;
  logic                      sclk_q;
  logic                      done_q;
  logic [4:0]                fall_cnt;
  logic [QW-1:0]             quiet_cnt;
  logic [DA2_FRAME_BITS-1:0] shift_a;
  logic [DA2_FRAME_BITS-1:0] shift_b;
  logic                      pend_valid;
  logic [DA2_FRAME_BITS-1:0] pend_a;
  logic [DA2_FRAME_BITS-1:0] pend_b;

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_b (reset_b),
    .en      (state == ST_FRAME),
    .tick    (tick)
  );

  // SCLK idles high, so a tick with sclk high is always a falling edge.
  assign fall_tick = tick && sclk_q;
  assign rise_tick = tick && !sclk_q;
  assign last_rise = rise_tick && (fall_cnt == 5'(DA2_FRAME_BITS));
  assign start     = (state == ST_IDLE) && (bus.load || pend_valid);

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FRAME;
      ST_FRAME: if (last_rise) state_nxt = ST_QUIET;
      ST_QUIET: if (quiet_cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.sync_n = (state != ST_FRAME);
    bus.sclk   = sclk_q;
    bus.dina   = (state == ST_FRAME) && shift_a[DA2_FRAME_BITS-1];
    bus.dinb   = (state == ST_FRAME) && shift_b[DA2_FRAME_BITS-1];
    bus.busy   = (state != ST_IDLE);
    bus.done   = done_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      sclk_q    <= 1'b1;
      done_q    <= 1'b0;
      fall_cnt  <= '0;
      quiet_cnt <= '0;
      shift_a   <= '0;
      shift_b   <= '0;
    end else begin
      done_q <= (state == ST_QUIET) && (quiet_cnt == '0);
      case (state)
        ST_IDLE: begin
          sclk_q   <= 1'b1;
          fall_cnt <= '0;
          // A fresh load beats an older pending word.
          if (start) begin
            shift_a <= bus.load ? da2_frame(bus.data_a) : pend_a;
            shift_b <= bus.load ? da2_frame(bus.data_b) : pend_b;
          end
        end
        ST_FRAME: begin
          if (tick) sclk_q <= ~sclk_q;
          if (fall_tick) fall_cnt <= fall_cnt + 5'd1;
          if (rise_tick) begin
            shift_a <= {shift_a[DA2_FRAME_BITS-2:0], 1'b0};
            shift_b <= {shift_b[DA2_FRAME_BITS-2:0], 1'b0};
          end
          if (last_rise) quiet_cnt <= QW'(QUIET - 1);
        end
        ST_QUIET: begin
          sclk_q <= 1'b1;
          if (quiet_cnt != '0) quiet_cnt <= quiet_cnt - 1'b1;
        end
        default: sclk_q <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      pend_valid <= 1'b0;
      pend_a     <= '0;
      pend_b     <= '0;
    end else if (bus.load && (state != ST_IDLE)) begin
      pend_valid <= 1'b1;
      pend_a     <= da2_frame(bus.data_a);
      pend_b     <= da2_frame(bus.data_b);
    end else if (start) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmod_da2_driver.sv
// Directed bench for pmod_da2_driver: frame capture on SCLK falls, protocol checks, pending/reset/back-to-back cases.
module tb_pmod_da2_driver;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  pmod_da2_driver_if if0 ();
  pmod_da2_driver_if if1 ();

  pmod_da2_driver #(.CLK_DIV(2), .QUIET(2)) u_dut0 (.clk(clk), .reset_b(reset_b), .bus(if0));
  pmod_da2_driver #(.CLK_DIV(1), .QUIET(2)) u_dut1 (.clk(clk), .reset_b(reset_b), .bus(if1));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic        prev_sync[2], prev_sclk[2], prev_da[2], prev_db[2];
  logic [15:0] sh_a[2], sh_b[2], last_a[2], last_b[2];
  int          nfall[2], last_nfall[2], frm_cnt[2], sync_falls[2], done_cnt[2];
  int          fall_cyc[2], rise_cyc[2], last_low[2], last_gap[2], last_done_dist[2];

  logic [15:0] t5_a[3] = '{16'h0A5A, 16'h5000, 16'h0001};
  logic [15:0] t5_b[3] = '{16'h0FFE, 16'h0002, 16'hFFFF};
  logic [15:0] t5_ea[4] = '{16'h0F0F, 16'h0A5A, 16'h0FFF, 16'h0001};
  logic [15:0] t5_eb[4] = '{16'h0321, 16'h0FFE, 16'h0002, 16'h0FFF};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mon_step(input int id, input logic s_n, input logic sc, input logic da,
                          input logic db, input logic dn);
    if (prev_sync[id] && !s_n) begin
      sync_falls[id]++;
      if (frm_cnt[id] > 0) last_gap[id] = cyc - rise_cyc[id];
      fall_cyc[id] = cyc;
      nfall[id] = 0;
      sh_a[id] = '0;
      sh_b[id] = '0;
    end
    if (prev_sclk[id] && !sc && !s_n) begin
      chk("stable_a_at_fall", da, prev_da[id]);
      chk("stable_b_at_fall", db, prev_db[id]);
      sh_a[id] = {sh_a[id][14:0], da};
      sh_b[id] = {sh_b[id][14:0], db};
      nfall[id]++;
    end
    if (!prev_sync[id] && s_n) begin
      frm_cnt[id]++;
      last_a[id] = sh_a[id];
      last_b[id] = sh_b[id];
      last_nfall[id] = nfall[id];
      last_low[id] = cyc - fall_cyc[id];
      rise_cyc[id] = cyc;
    end
    if (s_n) chk("idle_pins", {sc, da, db}, 3'b100);
    if (dn) begin
      done_cnt[id]++;
      last_done_dist[id] = cyc - rise_cyc[id];
    end
    prev_sync[id] = s_n;
    prev_sclk[id] = sc;
    prev_da[id] = da;
    prev_db[id] = db;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      mon_step(0, if0.sync_n, if0.sclk, if0.dina, if0.dinb, if0.done);
      mon_step(1, if1.sync_n, if1.sclk, if1.dina, if1.dinb, if1.done);
    end
  end

  function automatic logic dut_done(input int id);
    return (id == 0) ? if0.done : if1.done;
  endfunction

  task automatic drive_load(input int id, input logic [15:0] a, input logic [15:0] b);
    if (id == 0) begin
      if0.load = 1'b1; if0.data_a = a; if0.data_b = b;
    end else begin
      if1.load = 1'b1; if1.data_a = a; if1.data_b = b;
    end
  endtask

  task automatic drop_load(input int id);
    if (id == 0) if0.load = 1'b0;
    else if1.load = 1'b0;
  endtask

  task automatic load_word(input int id, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    drive_load(id, a, b);
    @(posedge clk); #1;
    drop_load(id);
  endtask

  task automatic wait_done(input int id, input string tag, input int budget);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (dut_done(id)) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk({tag, "_timeout"}, 0, 1);
    @(negedge clk); #1;
  endtask

  task automatic check_frame(input int id, input string tag, input logic [15:0] ea,
                             input logic [15:0] eb, input int elow);
    chk({tag, "_frame_a"}, last_a[id], ea);
    chk({tag, "_frame_b"}, last_b[id], eb);
    chk({tag, "_falls"}, last_nfall[id], 16);
    chk({tag, "_sync_low"}, last_low[id], elow);
    chk({tag, "_done_dist"}, last_done_dist[id], 2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int base, df, sf;
    bit hit;
    for (int i = 0; i < 2; i++) begin
      prev_sync[i] = 1'b1; prev_sclk[i] = 1'b1; prev_da[i] = 1'b0; prev_db[i] = 1'b0;
      sh_a[i] = '0; sh_b[i] = '0; last_a[i] = '0; last_b[i] = '0;
      nfall[i] = 0; last_nfall[i] = 0; frm_cnt[i] = 0; sync_falls[i] = 0; done_cnt[i] = 0;
      fall_cyc[i] = 0; rise_cyc[i] = 0; last_low[i] = 0; last_gap[i] = 0; last_done_dist[i] = 0;
    end
    if0.load = 1'b0; if0.data_a = '0; if0.data_b = '0;
    if1.load = 1'b0; if1.data_a = '0; if1.data_b = '0;

    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("reset_outs0", {if0.sync_n, if0.sclk, if0.dina, if0.dinb, if0.busy, if0.done}, 6'b110000);
    chk("reset_outs1", {if1.sync_n, if1.sclk, if1.dina, if1.dinb, if1.busy, if1.done}, 6'b110000);
    reset_b = 1'b1;
    repeat (2) @(posedge clk);

    // test 1: basic frame, latency, done timing
    @(posedge clk); #1;
    drive_load(0, 16'd3723, 16'd0);
    chk("t1_idle_before", if0.sync_n, 1);
    @(posedge clk); #1;
    drop_load(0);
    chk("t1_latency", if0.sync_n, 0);
    chk("t1_busy", if0.busy, 1);
    wait_done(0, "t1", 200);
    check_frame(0, "t1", 16'h0E8B, 16'h0000, 64);
    chk("t1_busy_at_done", if0.busy, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", if0.done, 0);

    // test 2: clamp
    load_word(0, 16'h1234, 16'h0FFF);
    wait_done(0, "t2", 200);
    check_frame(0, "t2", 16'h0FFF, 16'h0FFF, 64);

    // test 3: pending buffer, newest wins
    base = frm_cnt[0];
    load_word(0, 16'h0ABC, 16'h0011);
    repeat (8) @(posedge clk);
    load_word(0, 16'd100, 16'd7);
    repeat (8) @(posedge clk);
    load_word(0, 16'd200, 16'd9);
    wait_done(0, "t3a", 200);
    check_frame(0, "t3a", 16'h0ABC, 16'h0011, 64);
    wait_done(0, "t3b", 200);
    check_frame(0, "t3b", 16'd200, 16'd9, 64);
    chk("t3_gap", last_gap[0], 3);
    repeat (100) @(posedge clk);
    #1;
    chk("t3_frames", frm_cnt[0] - base, 2);
    chk("t3_idle", if0.busy, 0);

    // test 4: reset at falling edge 8 with a pending word
    load_word(0, 16'h0555, 16'h0AAA);
    repeat (4) @(posedge clk);
    load_word(0, 16'h0333, 16'h0000);
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (nfall[0] == 8) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("t4_fall8_timeout", 0, 1);
    reset_b = 1'b0;
    df = done_cnt[0];
    sf = sync_falls[0];
    @(posedge clk); #1;
    chk("t4_rst_outs", {if0.sync_n, if0.sclk, if0.busy, if0.done}, 4'b1100);
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(negedge clk); #1;
    chk("t4_abort_falls", last_nfall[0], 8);
    repeat (80) @(posedge clk);
    #1;
    chk("t4_no_done", done_cnt[0] - df, 0);
    chk("t4_pending_cleared", sync_falls[0] - sf, 0);
    load_word(0, 16'h0123, 16'h0FED);
    wait_done(0, "t4", 200);
    check_frame(0, "t4", 16'h0123, 16'h0FED, 64);

    // test 5: CLK_DIV=1, loads issued in the done cycle
    load_word(1, 16'h0F0F, 16'h0321);
    for (int i = 0; i < 3; i++) begin
      hit = 1'b0;
      for (int k = 0; k < 150; k++) begin
        @(posedge clk); #1;
        if (if1.done) begin
          drive_load(1, t5_a[i], t5_b[i]);
          hit = 1'b1;
          break;
        end
      end
      if (!hit) chk("t5_done_timeout", 0, 1);
      @(posedge clk); #1;
      drop_load(1);
      chk("t5_b2b_start", if1.sync_n, 0);
      @(negedge clk); #1;
      check_frame(1, "t5", t5_ea[i], t5_eb[i], 32);
      chk("t5_gap", last_gap[1], 3);
    end
    wait_done(1, "t5_last", 150);
    check_frame(1, "t5_last", t5_ea[3], t5_eb[3], 32);
    chk("t5_frames", frm_cnt[1], 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
